// File: rtl/mux_arb_pkg.sv
// Shared types for the two-source mux arbiter: FSM state encoding and
// select-line values.
package mux_arb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GNT_X = 2'd1,
      GNT_Y = 2'd2
   } state_t;

   localparam logic SEL_X = 1'b0;
   localparam logic SEL_Y = 1'b1;

endpackage

// File: rtl/mux_arbiter_if.sv
// Source-facing bus of the arbiter: requests and data in, grants, select
// and muxed data out.
interface mux_arbiter_if #(
   parameter int W = 4
);

   // Handshake: a source holds req_* high for as long as it wants the mux;
   // it owns the mux in every cycle its grant_* reads high, and it releases
   // the mux by dropping req_*. The arbiter only looks at edge-sampled values.
   logic         req_x;
   logic         req_y;
   logic [W-1:0] data_x;
   logic [W-1:0] data_y;
   logic         grant_x;
   logic         grant_y;
   logic         sel;
   logic [W-1:0] mux_out;
   logic         busy;

   modport master (
      output req_x, req_y, data_x, data_y,
      input  grant_x, grant_y, sel, mux_out, busy
   );

   modport slave (
      input  req_x, req_y, data_x, data_y,
      output grant_x, grant_y, sel, mux_out, busy
   );

endinterface

// File: rtl/hold_timer.sv
// Saturating grant-hold counter: cleared on grant entry, counts while a
// grant is held, flags when it has reached MAX_HOLD-1.
module hold_timer #(
   parameter int MAX_HOLD = 50_000_000
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         clear,
   input  logic                         enable,
   output logic                         saturated,
   output logic [$clog2(MAX_HOLD)-1:0]  count
);

   localparam int              CW   = $clog2(MAX_HOLD);
   localparam logic [CW-1:0]   LAST = CW'(MAX_HOLD - 1);

   logic [CW-1:0] r_cnt;
   logic          w_sat;

   assign w_sat = (r_cnt == LAST);

   // Clear wins over enable so a handover restarts the count from zero.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt <= '0;
      end else if (clear) begin
         r_cnt <= '0;
      end else if (enable && !w_sat) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   assign saturated = w_sat;
   assign count     = r_cnt;

endmodule

// File: rtl/mux_arbiter.sv
// Two-source round-robin mux arbiter with direct handover and a hold limit
// that only preempts the owner while the other source is waiting.
module mux_arbiter
   import mux_arb_pkg::*;
#(
   parameter int W        = 4,
   parameter int MAX_HOLD = 50_000_000
) (
   input  logic                         CLOCK_50,
   input  logic                         reset,
   mux_arbiter_if.slave                 bus,
   output state_t                       o_state,
   output logic [$clog2(MAX_HOLD)-1:0]  o_hold_cnt
);

   localparam int CW = $clog2(MAX_HOLD);

   state_t        r_state;
   state_t        w_next;
   logic          r_sel;
   logic          r_last;
   logic          w_entry;
   logic          w_next_sel;
   logic          w_sat;
   logic          w_grant_x;
   logic          w_grant_y;
   logic [CW-1:0] w_hold_cnt;

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE: begin
            if (bus.req_x && bus.req_y) begin
               w_next = (r_last == SEL_X) ? GNT_Y : GNT_X;
            end else if (bus.req_x) begin
               w_next = GNT_X;
            end else if (bus.req_y) begin
               w_next = GNT_Y;
            end
         end
         GNT_X: begin
            if (!bus.req_x) begin
               w_next = bus.req_y ? GNT_Y : IDLE;
            end else if (bus.req_y && w_sat) begin
               w_next = GNT_Y;
            end
         end
         GNT_Y: begin
            if (!bus.req_y) begin
               w_next = bus.req_x ? GNT_X : IDLE;
            end else if (bus.req_x && w_sat) begin
               w_next = GNT_X;
            end
         end
         default: w_next = IDLE;
      endcase
   end

   // Any move into a grant state, including X<->Y handover, is an entry.
   assign w_entry    = (w_next != r_state) && (w_next != IDLE);
   assign w_next_sel = (w_next == GNT_Y) ? SEL_Y : SEL_X;

   // r_last starts at SEL_Y so that X wins the first tie after reset.
   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         r_state <= IDLE;
         r_sel   <= SEL_X;
         r_last  <= SEL_Y;
      end else begin
         r_state <= w_next;
         if (w_entry) begin
            r_sel  <= w_next_sel;
            r_last <= w_next_sel;
         end
      end
   end

   hold_timer #(
      .MAX_HOLD (MAX_HOLD)
   ) u_hold_timer (
      .clk       (CLOCK_50),
      .rst       (reset),
      .clear     (w_entry),
      .enable    (r_state != IDLE),
      .saturated (w_sat),
      .count     (w_hold_cnt)
   );

   assign w_grant_x = (r_state == GNT_X);
   assign w_grant_y = (r_state == GNT_Y);

   always_comb begin
      bus.mux_out = '0;
      if (w_grant_x) begin
         bus.mux_out = bus.data_x;
      end else if (w_grant_y) begin
         bus.mux_out = bus.data_y;
      end
   end

   assign bus.grant_x = w_grant_x;
   assign bus.grant_y = w_grant_y;
   assign bus.sel     = r_sel;
   assign bus.busy    = w_grant_x | w_grant_y;
   assign o_state     = r_state;
   assign o_hold_cnt  = w_hold_cnt;

endmodule

// File: tb/tb_mux_arbiter.sv
// Directed bench for mux_arbiter with MAX_HOLD = 4, W = 4.
module tb_mux_arbiter;
   import mux_arb_pkg::*;

   logic       CLOCK_50;
   logic       reset;
   state_t     o_state;
   logic [1:0] o_hold_cnt;
   int         n_tests;
   int         n_fail;

   mux_arbiter_if #(.W(4)) bus ();

   mux_arbiter #(
      .W        (4),
      .MAX_HOLD (4)
   ) dut (
      .CLOCK_50   (CLOCK_50),
      .reset      (reset),
      .bus        (bus),
      .o_state    (o_state),
      .o_hold_cnt (o_hold_cnt)
   );

   initial CLOCK_50 = 1'b0;
   always #10 CLOCK_50 = ~CLOCK_50;

   task automatic tick(input int n);
      repeat (n) @(posedge CLOCK_50);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      n_tests    = 0;
      n_fail     = 0;
      reset      = 1'b1;
      bus.req_x  = 1'b0;
      bus.req_y  = 1'b0;
      bus.data_x = 4'hA;
      bus.data_y = 4'h5;

      tick(2);
      chk("rst_state",   32'(o_state), 32'(IDLE));
      chk("rst_grant_x", 32'(bus.grant_x), 32'd0);
      chk("rst_grant_y", 32'(bus.grant_y), 32'd0);
      chk("rst_sel",     32'(bus.sel), 32'd0);
      chk("rst_busy",    32'(bus.busy), 32'd0);
      chk("rst_mux_out", 32'(bus.mux_out), 32'h0);
      chk("rst_hold",    32'(o_hold_cnt), 32'd0);
      reset = 1'b0;

      // Single request from X
      bus.req_x = 1'b1;
      tick(1);
      chk("single_grant_x", 32'(bus.grant_x), 32'd1);
      chk("single_grant_y", 32'(bus.grant_y), 32'd0);
      chk("single_sel",     32'(bus.sel), 32'd0);
      chk("single_mux_out", 32'(bus.mux_out), 32'hA);
      chk("single_busy",    32'(bus.busy), 32'd1);

      bus.req_x = 1'b0;
      tick(1);
      chk("rel_state",   32'(o_state), 32'(IDLE));
      chk("rel_busy",    32'(bus.busy), 32'd0);
      chk("rel_mux_out", 32'(bus.mux_out), 32'h0);
      chk("rel_sel",     32'(bus.sel), 32'd0);

      // Tie straight out of reset, then handover without an idle gap
      reset = 1'b1;
      tick(1);
      reset     = 1'b0;
      bus.req_x = 1'b1;
      bus.req_y = 1'b1;
      tick(1);
      chk("tie_grant_x", 32'(bus.grant_x), 32'd1);
      chk("tie_grant_y", 32'(bus.grant_y), 32'd0);
      bus.req_x = 1'b0;
      tick(1);
      chk("hand_grant_y", 32'(bus.grant_y), 32'd1);
      chk("hand_grant_x", 32'(bus.grant_x), 32'd0);
      chk("hand_sel",     32'(bus.sel), 32'd1);
      chk("hand_mux_out", 32'(bus.mux_out), 32'h5);
      bus.req_y = 1'b0;
      tick(1);
      chk("idle_state",   32'(o_state), 32'(IDLE));
      chk("idle_sel",     32'(bus.sel), 32'd1);
      chk("idle_mux_out", 32'(bus.mux_out), 32'h0);
      chk("idle_busy",    32'(bus.busy), 32'd0);

      // Preemption: X holds exactly 4 cycles while Y waits, then back again
      bus.req_x = 1'b1;
      tick(1);
      chk("pre_x_entry", 32'(bus.grant_x), 32'd1);
      chk("pre_x_hold0", 32'(o_hold_cnt), 32'd0);
      bus.req_y = 1'b1;
      for (int i = 1; i <= 3; i++) begin
         tick(1);
         chk("pre_x_held", 32'(bus.grant_x), 32'd1);
         chk("pre_x_cnt",  32'(o_hold_cnt), 32'(i));
      end
      tick(1);
      chk("pre_to_y_grant_y", 32'(bus.grant_y), 32'd1);
      chk("pre_to_y_grant_x", 32'(bus.grant_x), 32'd0);
      chk("pre_to_y_sel",     32'(bus.sel), 32'd1);
      chk("pre_to_y_cnt",     32'(o_hold_cnt), 32'd0);
      chk("pre_to_y_mux",     32'(bus.mux_out), 32'h5);
      for (int i = 1; i <= 3; i++) begin
         tick(1);
         chk("pre_y_held", 32'(bus.grant_y), 32'd1);
         chk("pre_y_cnt",  32'(o_hold_cnt), 32'(i));
      end
      tick(1);
      chk("pre_to_x_grant_x", 32'(bus.grant_x), 32'd1);
      chk("pre_to_x_sel",     32'(bus.sel), 32'd0);
      chk("pre_to_x_mux",     32'(bus.mux_out), 32'hA);

      // Y alone holds indefinitely past saturation
      bus.req_x = 1'b0;
      tick(1);
      chk("solo_entry_y", 32'(bus.grant_y), 32'd1);
      chk("solo_sel",     32'(bus.sel), 32'd1);
      for (int i = 0; i < 20; i++) begin
         tick(1);
         chk("solo_y_held", 32'(bus.grant_y), 32'd1);
      end
      chk("solo_cnt_sat", 32'(o_hold_cnt), 32'd3);

      // Reset in the middle of GNT_Y, then a tie goes to X
      reset = 1'b1;
      tick(1);
      chk("midrst_grant_y", 32'(bus.grant_y), 32'd0);
      chk("midrst_sel",     32'(bus.sel), 32'd0);
      chk("midrst_mux_out", 32'(bus.mux_out), 32'h0);
      chk("midrst_busy",    32'(bus.busy), 32'd0);
      chk("midrst_state",   32'(o_state), 32'(IDLE));
      reset     = 1'b0;
      bus.req_x = 1'b1;
      tick(1);
      chk("posttie_grant_x", 32'(bus.grant_x), 32'd1);
      chk("posttie_grant_y", 32'(bus.grant_y), 32'd0);

      // A pulse that never spans a clock edge is invisible
      bus.req_x = 1'b0;
      bus.req_y = 1'b0;
      tick(1);
      chk("pulse_pre_idle", 32'(o_state), 32'(IDLE));
      #3 bus.req_y = 1'b1;
      #3 bus.req_y = 1'b0;
      tick(1);
      chk("pulse_state", 32'(o_state), 32'(IDLE));
      chk("pulse_busy",  32'(bus.busy), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
